ram_port_arbiter: RTL

- Round-robin arbiter sharing one port of a `ram_dp` instance among NUM_CLIENTS requesters. Routes 1-cycle-latency read data back to the client that issued the read.
- Contains a clear sequencer that fills the whole memory with CLEAR_VALUE, on command or after reset. Clients are blocked while the clear runs.
- Sits between datapath clients and the memory's port A. Port B stays free for a dedicated streaming user.

---
 rtl/ram_port_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_CLIENTS requesters, with read-data
// routing and a full-memory clear sequencer.
module ram_port_arbiter #(
  parameter int unsigned      NUM_CLIENTS    = 4,
  parameter int unsigned      WIDTH          = 64,
  parameter int unsigned      DEPTH          = 2048,
  parameter int unsigned      ADDR_BITS      = 11,
  parameter logic [WIDTH-1:0] CLEAR_VALUE    = {WIDTH{1'b1}},
  parameter bit               CLEAR_ON_RESET = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CLIENTS-1:0]           req_valid,
  input  logic [NUM_CLIENTS-1:0]           req_we,
  input  logic [NUM_CLIENTS*ADDR_BITS-1:0] req_addr,
  input  logic [NUM_CLIENTS*WIDTH-1:0]     req_wdata,
  output logic [NUM_CLIENTS-1:0]           req_ready,
  output logic [NUM_CLIENTS-1:0]           rsp_valid,
  output logic [WIDTH-1:0]                 rsp_data,
  input  logic                             clear_start,
  output logic                             busy,
  output logic                             clear_done,
  output logic                             mem_we,
  output logic [ADDR_BITS-1:0]             mem_addr,
  output logic [WIDTH-1:0]                 mem_wdata,
  input  logic [WIDTH-1:0]                 mem_rdata
);

  localparam int unsigned IDX_BITS = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                 state_q;
  logic [IDX_BITS-1:0]    last_grant_q;
  logic [ADDR_BITS-1:0]   clr_idx_q;
  logic [NUM_CLIENTS-1:0] rsp_valid_q;
  logic                   clear_done_q;

  logic [NUM_CLIENTS-1:0] grant;
  logic [IDX_BITS-1:0]    grant_idx;
  logic [IDX_BITS-1:0]    cand;
  logic                   found;
  int unsigned            idx;

  // Scan starting one past the last winner so every requester gets its turn.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    idx       = 0;
    if (!rst && state_q == StIdle) begin
      for (int k = 1; k <= int'(NUM_CLIENTS); k++) begin
        idx = int'(last_grant_q) + k;
        if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
        cand = IDX_BITS'(idx);
        if (!found && req_valid[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst && state_q == StClear) begin
      mem_we    = 1'b1;
      mem_addr  = clr_idx_q;
      mem_wdata = CLEAR_VALUE;
    end else if (found) begin
      mem_we    = req_we[grant_idx];
      mem_addr  = req_addr[grant_idx*ADDR_BITS +: ADDR_BITS];
      mem_wdata = req_wdata[grant_idx*WIDTH +: WIDTH];
    end
  end

  assign req_ready  = grant;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = mem_rdata;
  assign busy       = !rst && (state_q == StClear);
  assign clear_done = clear_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR_ON_RESET ? StClear : StIdle;
      last_grant_q <= IDX_BITS'(NUM_CLIENTS - 1);
      clr_idx_q    <= '0;
      rsp_valid_q  <= '0;
      clear_done_q <= 1'b0;
    end else begin
      rsp_valid_q  <= grant & ~req_we;
      clear_done_q <= 1'b0;
      if (found) last_grant_q <= grant_idx;
      unique case (state_q)
        StIdle: begin
          if (clear_start) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
          end
        end
        StClear: begin
          // clear_start is deliberately ignored here: no restart, no extra done.
          if (clr_idx_q == LAST_ADDR) begin
            state_q      <= StIdle;
            clr_idx_q    <= '0;
            clear_done_q <= 1'b1;
          end else begin
            clr_idx_q <= clr_idx_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
